fb_upload: RTL and testbench

//   Readback side of the framebuffer write path. Serves HPS ioctl upload requests by

---
 rtl/bocks_pkg.sv | 28 ++
 rtl/fb_pixel_packer.sv | 65 ++++++
 rtl/fb_upload.sv | 105 ++++++++++
 tb/tb_fb_upload.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bocks_pkg.sv
// Shared framebuffer constants for the VGA/font write path and the HPS readback path.
// Contents: frame geometry, pixel colour codes, default pack threshold,
//   upload FSM state encoding, byte-to-pixel address helpers.
package bocks_pkg;

  localparam int unsigned PIXEL_WIDTH  = 640;
  localparam int unsigned PIXEL_HEIGHT = 480;
  localparam int unsigned PIXEL_COUNT  = PIXEL_WIDTH * PIXEL_HEIGHT;
  localparam int unsigned BYTE_COUNT   = PIXEL_COUNT / 8;

  localparam logic [7:0] WHITE          = 8'hFF;
  localparam logic [7:0] BLACK          = 8'h00;
  localparam logic [7:0] THRESH_DEFAULT = 8'h80;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_READ = 1'b1;

  // First pixel covered by upload byte a (a*8); 27b*8 always fits in 32b.
  function automatic logic [31:0] byte_to_pixel(input logic [26:0] a);
    return {2'b00, a, 3'b000};
  endfunction

  // True when byte address a lies inside the upload image.
  function automatic logic in_image(input logic [26:0] a);
    return 32'(a) < BYTE_COUNT;
  endfunction

endpackage

// File: rtl/fb_pixel_packer.sv
// Return side of the upload gather: tracks outstanding framebuffer reads with a
//   RD_LATENCY-deep valid delay line, thresholds each returned pixel into one bit,
//   shifts bits MSB-first and flags the eighth return.
// Ports: clk/rst_n; flush (drop in-flight reads); issue (fb_rd as driven this cycle);
//   rd_data (framebuffer pixel); byte_out/done (completed byte, valid while done=1).
module fb_pixel_packer
  import bocks_pkg::*;
#(
  parameter int         RD_LATENCY = 1,
  parameter logic [7:0] THRESH     = THRESH_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       issue,
  input  logic [7:0] rd_data,
  output logic [7:0] byte_out,
  output logic       done
);

  logic [RD_LATENCY-1:0] vld_line;
  logic                  ret_vld;
  logic                  pix_bit;
  logic [6:0]            shreg;
  logic [2:0]            ret_cnt;

  // vld_line[k] set means the read issued k+1 cycles ago is still in flight;
  // the top bit lines up with fb_rd_data being valid this cycle.
  generate
    if (RD_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     vld_line <= '0;
        else if (flush) vld_line <= '0;
        else            vld_line <= issue;
      end
    end else begin : g_latn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     vld_line <= '0;
        else if (flush) vld_line <= '0;
        else            vld_line <= {vld_line[RD_LATENCY-2:0], issue};
      end
    end
  endgenerate

  assign ret_vld = vld_line[RD_LATENCY-1];
  assign pix_bit = (rd_data >= THRESH);

  // Only seven bits are held: the eighth is the live return, merged into byte_out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      ret_cnt <= '0;
    end else if (flush) begin
      shreg   <= '0;
      ret_cnt <= '0;
    end else if (ret_vld) begin
      shreg   <= {shreg[5:0], pix_bit};
      ret_cnt <= ret_cnt + 3'd1;
    end
  end

  assign byte_out = {shreg, pix_bit};
  assign done     = ret_vld && (ret_cnt == 3'd7);

endmodule

// File: rtl/fb_upload.sv
// HPS ioctl upload readback: each accepted byte request reads 8 consecutive
//   framebuffer pixels and packs them into one 1bpp byte (bit7 = first pixel).
// Ports: pclk/reset_n; ioctl_upload/rd/addr/din/wait (HPS side);
//   fb_rd/fb_addr/fb_rd_data (framebuffer read port, RD_LATENCY cycles to data).
module fb_upload
  import bocks_pkg::*;
#(
  parameter int         RD_LATENCY = 1,
  parameter logic [7:0] THRESH     = THRESH_DEFAULT
) (
  input  logic        pclk,
  input  logic        reset_n,
  input  logic        ioctl_upload,
  input  logic        ioctl_rd,
  input  logic [26:0] ioctl_addr,
  output logic [7:0]  ioctl_din,
  output logic        ioctl_wait,
  output logic        fb_rd,
  output logic [31:0] fb_addr,
  input  logic [7:0]  fb_rd_data
);

  logic [1:0] rst_sync;
  logic       rst_n_int;
  logic [0:0] state;
  logic [2:0] issue_cnt;
  logic       req;
  logic       abort;
  logic       pk_done;
  logic [7:0] pk_byte;

  // Reset asserts immediately but releases two pclk edges later, so no flop
  // sees reset removal close to an active edge.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_int = rst_sync[1];

  assign req   = ioctl_rd && ioctl_upload;
  assign abort = (state == ST_READ) && !ioctl_upload;

  always_ff @(posedge pclk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state      <= ST_IDLE;
      issue_cnt  <= '0;
      ioctl_din  <= '0;
      ioctl_wait <= 1'b0;
      fb_rd      <= 1'b0;
      fb_addr    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            if (in_image(ioctl_addr)) begin
              state      <= ST_READ;
              ioctl_wait <= 1'b1;
              fb_rd      <= 1'b1;
              fb_addr    <= byte_to_pixel(ioctl_addr);
              issue_cnt  <= '0;
            end else begin
              // Past the end of the image reads back as blank, without a wait phase.
              ioctl_din <= 8'h00;
            end
          end
        end
        ST_READ: begin
          if (abort) begin
            // Session gone: drop the gather, keep the last good byte on ioctl_din.
            state      <= ST_IDLE;
            ioctl_wait <= 1'b0;
            fb_rd      <= 1'b0;
            issue_cnt  <= '0;
          end else begin
            if (fb_rd) begin
              issue_cnt <= issue_cnt + 3'd1;
              if (issue_cnt == 3'd7) fb_rd   <= 1'b0;
              else                   fb_addr <= fb_addr + 32'd1;
            end
            if (pk_done) begin
              ioctl_din  <= pk_byte;
              ioctl_wait <= 1'b0;
              state      <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  fb_pixel_packer #(
    .RD_LATENCY (RD_LATENCY),
    .THRESH     (THRESH)
  ) u_packer (
    .clk      (pclk),
    .rst_n    (rst_n_int),
    .flush    (abort),
    .issue    (fb_rd),
    .rd_data  (fb_rd_data),
    .byte_out (pk_byte),
    .done     (pk_done)
  );

endmodule

// File: tb/tb_fb_upload.sv
// Bench for fb_upload: two instances (read latency 1 and 3) share the HPS-side
//   stimulus; each has its own model framebuffer with a matching read pipeline.
module tb_fb_upload;

  localparam int unsigned BYTES = 38400;

  logic        pclk;
  logic        reset_n;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [26:0] ioctl_addr;

  logic [7:0]  din_l1, din_l3;
  logic        wait_l1, wait_l3;
  logic        fb_rd_l1, fb_rd_l3;
  logic [31:0] fb_addr_l1, fb_addr_l3;
  logic [7:0]  fb_data_l1, fb_data_l3;

  int nvec  = 0;
  int nfail = 0;

  logic [7:0]  fb_tab [64];
  logic [31:0] q1[$];
  logic [31:0] q3[$];
  logic [7:0]  p1;
  logic [7:0]  p3 [3];

  fb_upload #(.RD_LATENCY(1)) dut_l1 (
    .pclk(pclk), .reset_n(reset_n), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(din_l1), .ioctl_wait(wait_l1),
    .fb_rd(fb_rd_l1), .fb_addr(fb_addr_l1), .fb_rd_data(fb_data_l1));

  fb_upload #(.RD_LATENCY(3)) dut_l3 (
    .pclk(pclk), .reset_n(reset_n), .ioctl_upload(ioctl_upload), .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr), .ioctl_din(din_l3), .ioctl_wait(wait_l3),
    .fb_rd(fb_rd_l3), .fb_addr(fb_addr_l3), .fb_rd_data(fb_data_l3));

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Model framebuffer: pixel at address p is fb_tab[p mod 64]; junk when not read.
  always @(posedge pclk) begin
    p1    <= fb_rd_l1 ? fb_tab[fb_addr_l1[5:0]] : 8'($urandom);
    p3[0] <= fb_rd_l3 ? fb_tab[fb_addr_l3[5:0]] : 8'($urandom);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign fb_data_l1 = p1;
  assign fb_data_l3 = p3[2];

  // Every framebuffer read must match the next expected address.
  always @(negedge pclk) begin
    if (fb_rd_l1) begin
      if (q1.size() == 0) chk("unexpected_fb_rd_l1", fb_addr_l1, 32'hFFFF_FFFF);
      else                chk("fb_addr_l1", fb_addr_l1, q1.pop_front());
    end
    if (fb_rd_l3) begin
      if (q3.size() == 0) chk("unexpected_fb_rd_l3", fb_addr_l3, 32'hFFFF_FFFF);
      else                chk("fb_addr_l3", fb_addr_l3, q3.pop_front());
    end
  end

  // Reference: byte a = 8 pixels 8a..8a+7, MSB first, bit = pixel >= 0x80.
  function automatic logic [7:0] model_byte(input logic [26:0] a);
    logic [7:0] r;
    int unsigned p;
    r = 8'h00;
    if (32'(a) >= BYTES) return 8'h00;
    for (int i = 0; i < 8; i++) begin
      p = 32'(a) * 8 + i;
      r[7-i] = (fb_tab[p % 64] >= 8'h80);
    end
    return r;
  endfunction

  task automatic push_addrs(input logic [26:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      q1.push_back(32'(a) * 8 + 32'(i));
      q3.push_back(32'(a) * 8 + 32'(i));
    end
  endtask

  // Issue one byte read; h1/h3 = negedges each instance held wait high.
  task automatic do_req(input logic [26:0] a, input bit viol, output int h1, output int h3);
    bit z1, z3;
    if (32'(a) < BYTES && ioctl_upload) push_addrs(a, 8);
    @(negedge pclk);
    ioctl_addr = a;
    ioctl_rd   = 1'b1;
    @(negedge pclk);
    ioctl_rd = 1'b0;
    h1 = 0; h3 = 0; z1 = 0; z3 = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) @(negedge pclk);
      if (viol && k == 2) begin ioctl_rd = 1'b1; ioctl_addr = 27'd0; end
      if (viol && k == 3) ioctl_rd = 1'b0;
      if (!z1) begin if (wait_l1) h1++; else z1 = 1; end
      if (!z3) begin if (wait_l3) h3++; else z3 = 1; end
      if (z1 && z3) break;
    end
    @(posedge pclk);
    #1;
  endtask

  task automatic check_req(input string name, input logic [7:0] exp_din,
                           input int exp_h1, input int exp_h3, input int h1, input int h3);
    chk({name, "_wait_cycles_l1"}, 32'(h1), 32'(exp_h1));
    chk({name, "_wait_cycles_l3"}, 32'(h3), 32'(exp_h3));
    chk({name, "_din_l1"}, 32'(din_l1), 32'(exp_din));
    chk({name, "_din_l3"}, 32'(din_l3), 32'(exp_din));
    chk({name, "_reads_left_l1"}, 32'(q1.size()), 32'd0);
    chk({name, "_reads_left_l3"}, 32'(q3.size()), 32'd0);
    q1.delete();
    q3.delete();
  endtask

  typedef struct {
    logic [26:0] addr;
    logic [7:0]  exp_din;
    int          exp_h1;
    int          exp_h3;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int h1, h3;
    logic [26:0] a;
    logic [7:0] hold;

    for (int i = 0; i < 64; i++) fb_tab[i] = 8'($urandom);
    fb_tab[0] = 8'hFF; fb_tab[1] = 8'h00; fb_tab[2] = 8'hFF; fb_tab[3] = 8'h00;
    fb_tab[4] = 8'hFF; fb_tab[5] = 8'h00; fb_tab[6] = 8'hFF; fb_tab[7] = 8'h00;
    fb_tab[8]  = 8'h7F; fb_tab[9]  = 8'h80; fb_tab[10] = 8'h00; fb_tab[11] = 8'hFF;
    fb_tab[12] = 8'h81; fb_tab[13] = 8'h7F; fb_tab[14] = 8'h80; fb_tab[15] = 8'h01;
    fb_tab[56] = 8'h80; fb_tab[57] = 8'h80; fb_tab[58] = 8'h00; fb_tab[59] = 8'h00;
    fb_tab[60] = 8'hFF; fb_tab[61] = 8'h7F; fb_tab[62] = 8'h81; fb_tab[63] = 8'h00;

    tbl[0] = '{27'd0,     8'hAA, 9, 11};
    tbl[1] = '{27'd1,     8'h5A, 9, 11};
    tbl[2] = '{27'd38399, 8'hCA, 9, 11};
    tbl[3] = '{27'd38400, 8'h00, 0, 0};
    tbl[4] = '{27'd0,     8'hAA, 9, 11};

    reset_n      = 1'b0;
    ioctl_upload = 1'b1;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;

    // Reset state
    #12;
    chk("rst_din_l1", 32'(din_l1), 0);   chk("rst_din_l3", 32'(din_l3), 0);
    chk("rst_wait_l1", 32'(wait_l1), 0); chk("rst_wait_l3", 32'(wait_l3), 0);
    chk("rst_fb_rd_l1", 32'(fb_rd_l1), 0); chk("rst_fb_rd_l3", 32'(fb_rd_l3), 0);
    chk("rst_fb_addr_l1", fb_addr_l1, 0);  chk("rst_fb_addr_l3", fb_addr_l3, 0);
    @(negedge pclk);
    reset_n = 1'b1;
    repeat (4) @(negedge pclk);

    // Directed table: pattern, threshold edges, last byte, out of range
    for (int i = 0; i < 5; i++) begin
      do_req(tbl[i].addr, 1'b0, h1, h3);
      check_req($sformatf("tbl%0d", i), tbl[i].exp_din, tbl[i].exp_h1, tbl[i].exp_h3, h1, h3);
    end

    // Upload dropped 3 cycles into a read: abort, byte unchanged
    do_req(27'd1, 1'b0, h1, h3);
    check_req("pre_abort", 8'h5A, 9, 11, h1, h3);
    push_addrs(27'd0, 3);
    @(negedge pclk);
    ioctl_addr = 27'd0;
    ioctl_rd   = 1'b1;
    @(negedge pclk);
    ioctl_rd = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    ioctl_upload = 1'b0;
    @(negedge pclk);
    chk("abort_wait_l1", 32'(wait_l1), 0);   chk("abort_wait_l3", 32'(wait_l3), 0);
    chk("abort_fb_rd_l1", 32'(fb_rd_l1), 0); chk("abort_fb_rd_l3", 32'(fb_rd_l3), 0);
    repeat (5) @(negedge pclk);
    chk("abort_din_l1", 32'(din_l1), 32'h5A); chk("abort_din_l3", 32'(din_l3), 32'h5A);
    chk("abort_reads_l1", 32'(q1.size()), 0); chk("abort_reads_l3", 32'(q3.size()), 0);
    q1.delete(); q3.delete();
    ioctl_upload = 1'b1;
    do_req(27'd0, 1'b0, h1, h3);
    check_req("post_abort", 8'hAA, 9, 11, h1, h3);

    // Read strobe without an upload session: ignored, byte holds
    ioctl_upload = 1'b0;
    do_req(27'd1, 1'b0, h1, h3);
    check_req("no_session", 8'hAA, 0, 0, h1, h3);
    ioctl_upload = 1'b1;

    // Second strobe while waiting: ignored
    do_req(27'd3, 1'b1, h1, h3);
    check_req("rd_during_wait", model_byte(27'd3), 9, 11, h1, h3);

    // Reset in the middle of a read
    push_addrs(27'd2, 4);
    @(negedge pclk);
    ioctl_addr = 27'd2;
    ioctl_rd   = 1'b1;
    @(negedge pclk);
    ioctl_rd = 1'b0;
    repeat (3) @(negedge pclk);
    @(posedge pclk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_din_l1", 32'(din_l1), 0);     chk("midrst_din_l3", 32'(din_l3), 0);
    chk("midrst_wait_l1", 32'(wait_l1), 0);   chk("midrst_wait_l3", 32'(wait_l3), 0);
    chk("midrst_fb_rd_l1", 32'(fb_rd_l1), 0); chk("midrst_fb_rd_l3", 32'(fb_rd_l3), 0);
    chk("midrst_fb_addr_l1", fb_addr_l1, 0);  chk("midrst_fb_addr_l3", fb_addr_l3, 0);
    @(negedge pclk);
    reset_n = 1'b1;
    repeat (4) @(negedge pclk);
    chk("midrst_reads_l1", 32'(q1.size()), 0); chk("midrst_reads_l3", 32'(q3.size()), 0);
    q1.delete(); q3.delete();
    do_req(27'd1, 1'b0, h1, h3);
    check_req("post_reset", 8'h5A, 9, 11, h1, h3);

    // Random requests against the reference
    for (int n = 0; n < 24; n++) begin
      if (n % 6 == 5) a = 27'($urandom);
      else            a = 27'($urandom_range(0, BYTES + 8));
      if (n % 4 == 0) begin
        fb_tab[$urandom_range(16, 55)] = 8'($urandom);
      end
      hold = model_byte(a);
      do_req(a, 1'b0, h1, h3);
      if (32'(a) < BYTES) check_req($sformatf("rand%0d", n), hold, 9, 11, h1, h3);
      else                check_req($sformatf("rand%0d", n), 8'h00, 0, 0, h1, h3);
    end

    repeat (4) @(negedge pclk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    nfail++;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $fatal(1, "watchdog");
  end

endmodule
